// File: rtl/uart_readout_ctrl.sv
// uart_readout_ctrl: capture readout sequencer.
// Fetches 4-word PSRAM bursts into a 4-in/1-out FIFO and drains it one word
// at a time to the UART TX, high byte first. The FIFO's own flags lag by a
// cycle, so fill level is tracked here as an occupancy credit (occ).
// Optional build macro UART_CHECKSUM_EN appends an XOR-of-all-bytes trailer.
module uart_readout_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int ADDR_WIDTH = 21
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] sample_count,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_ack,
  output logic                  fifo_reset,
  output logic                  fifo_wr_en,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy
);

  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  // A burst may only be requested while 4 free slots are guaranteed.
  localparam logic [OCC_W-1:0] OCC_LIMIT = OCC_W'(FIFO_DEPTH - 4);

  typedef enum logic {F_IDLE, F_REQ} fetch_t;
  typedef enum logic [3:0] {
    D_IDLE, D_POP, D_WAIT, D_HI, D_HIG, D_LO, D_LOG
`ifdef UART_CHECKSUM_EN
    , D_CK, D_CKG
`endif
  } drain_t;

  fetch_t                fstate;
  drain_t                dstate;
  logic [ADDR_WIDTH-1:0] count_q;
  logic [ADDR_WIDTH-1:0] bursts_left;
  logic [ADDR_WIDTH-1:0] words_sent;
  logic [OCC_W-1:0]      occ;
  logic [DATA_WIDTH-1:0] word_q;
  logic [7:0]            hi_byte;
  logic [7:0]            lo_byte;
  logic                  start_acc;
  logic                  push;
  logic                  finished;
  logic [ADDR_WIDTH:0]   cnt_p3;
  logic [ADDR_WIDTH-1:0] bursts_init;

`ifdef UART_CHECKSUM_EN
  logic [7:0]            csum;
  logic                  ck_sent;
`endif

  assign start_acc  = start && !busy;
  // FIFO push is tied straight to the ack so the 4 words land the same cycle.
  assign push       = (fstate == F_REQ) && rd_ack;
  assign fifo_wr_en = push;

  // ceil(sample_count/4) without overflow at the top of the range
  assign cnt_p3      = {1'b0, sample_count} + (ADDR_WIDTH+1)'(3);
  assign bursts_init = {1'b0, cnt_p3[ADDR_WIDTH:2]};

  // Everything fetched, drained and (optionally) the trailer sent.
  assign finished = (bursts_left == '0) && (occ == '0) &&
                    (dstate == D_IDLE) && (fstate == F_IDLE)
`ifdef UART_CHECKSUM_EN
                    && ck_sent
`endif
                    ;

  generate
    if (DATA_WIDTH == 16) begin : g_hi16
      assign hi_byte = word_q[15:8];
    end else begin : g_hi12
      assign hi_byte = {4'b0000, word_q[11:8]};
    end
  endgenerate
  assign lo_byte = word_q[7:0];

  // Readout control: start accept, FIFO clear, completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      fifo_reset <= 1'b0;
      count_q    <= '0;
    end else begin
      done       <= 1'b0;
      fifo_reset <= 1'b0;
      if (start_acc) begin
        busy       <= 1'b1;
        fifo_reset <= 1'b1;
        count_q    <= sample_count;
      end else if (busy && finished) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  // Fetch FSM: one outstanding burst at a time, gated by free-slot credit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fstate      <= F_IDLE;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      bursts_left <= '0;
    end else if (start_acc) begin
      fstate      <= F_IDLE;
      rd_req      <= 1'b0;
      rd_addr     <= base_addr;
      bursts_left <= bursts_init;
    end else begin
      case (fstate)
        F_IDLE: begin
          if (busy && (bursts_left != '0) && (occ <= OCC_LIMIT)) begin
            fstate <= F_REQ;
            rd_req <= 1'b1;
          end
        end
        F_REQ: begin
          if (rd_ack) begin
            fstate      <= F_IDLE;
            rd_req      <= 1'b0;
            rd_addr     <= rd_addr + ADDR_WIDTH'(4);
            bursts_left <= bursts_left - ADDR_WIDTH'(1);
          end
        end
        default: fstate <= F_IDLE;
      endcase
    end
  end

  // Occupancy credit: +4 per burst push, -1 per word pop, both together +3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ <= '0;
    end else if (start_acc) begin
      occ <= '0;
    end else begin
      case ({push, fifo_rd_en})
        2'b10:   occ <= occ + OCC_W'(4);
        2'b01:   occ <= occ - OCC_W'(1);
        2'b11:   occ <= occ + OCC_W'(3);
        default: occ <= occ;
      endcase
    end
  end

  // Drain FSM: pop, capture, send high then low byte with a guard cycle
  // after each launch so the UART's lagging tx_busy is never misread.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dstate     <= D_IDLE;
      fifo_rd_en <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      word_q     <= '0;
      words_sent <= '0;
`ifdef UART_CHECKSUM_EN
      csum       <= '0;
      ck_sent    <= 1'b0;
`endif
    end else begin
      fifo_rd_en <= 1'b0;
      tx_start   <= 1'b0;
      if (start_acc) begin
        dstate     <= D_IDLE;
        words_sent <= '0;
`ifdef UART_CHECKSUM_EN
        csum       <= '0;
        ck_sent    <= 1'b0;
`endif
      end else begin
        case (dstate)
          D_IDLE: begin
            if (occ != '0) begin
              dstate     <= D_POP;
              fifo_rd_en <= 1'b1;
            end
`ifdef UART_CHECKSUM_EN
            else if (busy && (bursts_left == '0) && (fstate == F_IDLE) && !ck_sent)
              dstate <= D_CK;
`endif
          end
          D_POP:  dstate <= D_WAIT;
          D_WAIT: begin
            word_q <= fifo_data;
            // Words beyond sample_count are tail padding of the last burst.
            if (words_sent >= count_q) dstate <= D_IDLE;
            else                       dstate <= D_HI;
          end
          D_HI: begin
            if (!tx_busy) begin
              tx_data  <= hi_byte;
              tx_start <= 1'b1;
`ifdef UART_CHECKSUM_EN
              csum     <= csum ^ hi_byte;
`endif
              dstate   <= D_HIG;
            end
          end
          D_HIG:  dstate <= D_LO;
          D_LO: begin
            if (!tx_busy) begin
              tx_data  <= lo_byte;
              tx_start <= 1'b1;
`ifdef UART_CHECKSUM_EN
              csum     <= csum ^ lo_byte;
`endif
              dstate   <= D_LOG;
            end
          end
          D_LOG: begin
            words_sent <= words_sent + ADDR_WIDTH'(1);
            dstate     <= D_IDLE;
          end
`ifdef UART_CHECKSUM_EN
          D_CK: begin
            if (!tx_busy) begin
              tx_data  <= csum;
              tx_start <= 1'b1;
              ck_sent  <= 1'b1;
              dstate   <= D_CKG;
            end
          end
          D_CKG:  dstate <= D_IDLE;
`endif
          default: dstate <= D_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_readout_ctrl.sv
// Bench for uart_readout_ctrl: behavioural PSRAM, FIFO (queue) and UART
// models; expected byte stream and burst addresses derived from memory
// contents and the readout rules.
module tb_uart_readout_ctrl;
  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int AW    = 21;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] sample_count = '0;
  logic          busy, done, rd_req, fifo_reset, fifo_wr_en, fifo_rd_en, tx_start;
  logic [AW-1:0] rd_addr;
  logic          rd_ack = 1'b0;
  logic [DW-1:0] fifo_data = '0;
  logic [7:0]    tx_data;
  logic          tx_busy = 1'b0;

  uart_readout_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .sample_count(sample_count), .busy(busy), .done(done), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_ack(rd_ack), .fifo_reset(fifo_reset),
    .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0]   mem [0:8191];
  logic [15:0]   fq[$];
  logic [7:0]    rx[$];
  logic [AW-1:0] req_log[$];
  int done_cnt = 0, push_cnt = 0, pop_cnt = 0, max_occ = 0;
  int lat = 3, busy_len = 0;
  bit force_ack = 0;

  // model state
  bit            p_pend = 0, ack_next = 0, dv = 0;
  int            p_cnt = 0, u_cnt = 0;
  logic [AW-1:0] p_addr = '0;
  logic [15:0]   dword = '0;

  // Environment: drive inputs just after posedge, observe at negedge.
  initial begin
    forever begin
      @(posedge clk); #1;
      rd_ack    = ack_next || force_ack;
      ack_next  = 0;
      tx_busy   = (u_cnt > 0);
      fifo_data = dv ? dword : DW'($urandom);
      @(negedge clk);
      if (reset) begin
        fq.delete(); p_pend = 0; u_cnt = 0; dv = 0; ack_next = 0;
      end else begin
        if (fifo_reset) fq.delete();
        checks++;
        if (fifo_wr_en !== (rd_ack && rd_req)) begin
          errors++;
          $display("FAIL wr_en_vs_ack: fifo_wr_en=%b rd_ack=%b rd_req=%b", fifo_wr_en, rd_ack, rd_req);
        end
        if (fifo_wr_en) begin
          checks++;
          if (fq.size() > DEPTH - 4) begin
            errors++;
            $display("FAIL push_overflow: occupancy=%0d before push, limit=%0d", fq.size(), DEPTH - 4);
          end
          for (int j = 0; j < 4; j++) fq.push_back(mem[(rd_addr + j) & 8191]);
          push_cnt++;
          p_pend = 0;
        end else if (rd_req) begin
          if (!p_pend) begin
            p_pend = 1; p_addr = rd_addr; p_cnt = lat;
            req_log.push_back(rd_addr);
            checks++;
            if (fq.size() > DEPTH - 4) begin
              errors++;
              $display("FAIL req_when_full: occupancy=%0d, limit=%0d", fq.size(), DEPTH - 4);
            end
          end else begin
            checks++;
            if (rd_addr !== p_addr) begin
              errors++;
              $display("FAIL rd_addr_stable: got %h want %h", rd_addr, p_addr);
            end
          end
          if (p_cnt > 0) p_cnt--;
          if (p_cnt == 0) ack_next = 1;
        end
        if (fq.size() > max_occ) max_occ = fq.size();
        dv = 0;
        if (fifo_rd_en) begin
          checks++;
          if (fq.size() == 0) begin
            errors++;
            $display("FAIL pop_underflow: popped an empty fifo");
          end else begin
            dword = fq.pop_front(); dv = 1; pop_cnt++;
          end
        end
        if (tx_start) begin
          checks++;
          if (tx_busy) begin
            errors++;
            $display("FAIL tx_start_while_busy: tx_busy=%b want 0", tx_busy);
          end
          rx.push_back(tx_data);
          u_cnt = busy_len;
        end else if (u_cnt > 0) u_cnt--;
        if (done) done_cnt++;
      end
    end
  end

  task automatic clear_logs();
    rx.delete(); req_log.delete();
    done_cnt = 0; push_cnt = 0; pop_cnt = 0; max_occ = 0;
  endtask

  // Full readout with end-of-run checks; poke pulses a stray start mid-run.
  task automatic run_readout(input logic [AW-1:0] b, input logic [AW-1:0] n,
                             input int l, input int bl, input bit poke);
    logic [7:0]  exp[$];
    logic [7:0]  ck;
    logic [15:0] w;
    int nb;
    ck = 8'h00;
    for (int i = 0; i < int'(n); i++) begin
      w = mem[(b + i) & 8191];
      exp.push_back(w[15:8]); exp.push_back(w[7:0]);
      ck = ck ^ w[15:8] ^ w[7:0];
    end
`ifdef UART_CHECKSUM_EN
    exp.push_back(ck);
`endif
    nb = (int'(n) + 3) / 4;
    clear_logs();
    lat = l; busy_len = bl;
    @(posedge clk); #1;
    base_addr = b; sample_count = n; start = 1;
    @(posedge clk); #1;
    start = 0; base_addr = AW'($urandom); sample_count = AW'($urandom);
    if (poke) begin
      repeat (6) @(posedge clk);
      #1; start = 1;
      @(posedge clk); #1; start = 0;
    end
    for (int c = 0; c < 20000 && done_cnt == 0; c++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL done_timeout: no done for base=%h count=%0d", b, n);
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL done_count: got %0d want 1", done_cnt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done: got %b want 0", busy); end
    checks++;
    if (rx.size() != exp.size()) begin
      errors++; $display("FAIL byte_count: got %0d want %0d", rx.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (rx[i] !== exp[i]) begin
          errors++; $display("FAIL tx_byte[%0d]: got %h want %h", i, rx[i], exp[i]);
        end
      end
    end
    checks++;
    if (req_log.size() != nb) begin
      errors++; $display("FAIL burst_count: got %0d want %0d", req_log.size(), nb);
    end else begin
      for (int i = 0; i < nb; i++) begin
        checks++;
        if (req_log[i] !== AW'(b + 4 * i)) begin
          errors++; $display("FAIL burst_addr[%0d]: got %h want %h", i, req_log[i], AW'(b + 4 * i));
        end
      end
    end
    checks++;
    if (pop_cnt != 4 * nb) begin errors++; $display("FAIL pop_count: got %0d want %0d", pop_cnt, 4 * nb); end
    checks++;
    if (fq.size() != 0) begin errors++; $display("FAIL fifo_not_empty: got %0d want 0", fq.size()); end
    checks++;
    if (max_occ > DEPTH) begin errors++; $display("FAIL max_occ: got %0d want <=%0d", max_occ, DEPTH); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, rd_req, fifo_reset, fifo_wr_en, fifo_rd_en, tx_start} !== 7'b0 ||
        rd_addr !== '0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b rd_req=%b rd_addr=%h tx_data=%h want all 0",
               busy, done, rd_req, rd_addr, tx_data);
    end
    @(posedge clk); #1; reset = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rd_req !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b rd_req=%b want 0", busy, rd_req);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 8; i++) mem[16'h100 + i] = 16'h1234 + 16'h1111 * i[15:0];
    run_readout(AW'(16'h100), AW'(8), 3, 0, 1'b1);
    checks++;
    if (rx.size() < 2 || rx[0] !== 8'h12 || rx[1] !== 8'h34) begin
      errors++; $display("FAIL first_word_bytes: got %0d bytes, want 12 34 first", rx.size());
    end
    checks++;
    if (req_log.size() != 2 || req_log[0] !== AW'(16'h100) || req_log[1] !== AW'(16'h104)) begin
      errors++; $display("FAIL basic_addrs: got %0d requests, want 100 then 104", req_log.size());
    end
  endtask

  task automatic test_padding();
    run_readout(AW'(16'h300), AW'(6), 2, 1, 1'b0);
  endtask

  task automatic test_backpressure();
    run_readout(AW'(16'h400), AW'(40), 3, 100, 1'b0);
    checks++;
    if (push_cnt != 10) begin errors++; $display("FAIL bp_pushes: got %0d want 10", push_cnt); end
  endtask

  task automatic test_zero_count();
    clear_logs();
    lat = 3; busy_len = 2;
    @(posedge clk); #1;
    base_addr = AW'(16'h500); sample_count = '0; start = 1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL zero_pre_busy: got %b want 0", busy); end
    @(posedge clk); #1; start = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || fifo_reset !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL zero_accept: busy=%b fifo_reset=%b done=%b want 1 1 0", busy, fifo_reset, done);
    end
`ifndef UART_CHECKSUM_EN
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_done: done=%b busy=%b want 1 0", done, busy);
    end
`else
    for (int c = 0; c < 100 && done_cnt == 0; c++) begin
      @(negedge clk); #1;
    end
`endif
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
    checks++;
    if (req_log.size() != 0) begin errors++; $display("FAIL zero_rd_req: got %0d requests want 0", req_log.size()); end
`ifdef UART_CHECKSUM_EN
    checks++;
    if (rx.size() != 1 || rx[0] !== 8'h00) begin
      errors++; $display("FAIL zero_checksum: got %0d bytes, want single 00", rx.size());
    end
`else
    checks++;
    if (rx.size() != 0) begin errors++; $display("FAIL zero_tx: got %0d bytes want 0", rx.size()); end
`endif
  endtask

  task automatic test_reset_mid();
    int c;
    clear_logs();
    lat = 6; busy_len = 0;
    @(posedge clk); #1;
    base_addr = AW'(16'h600); sample_count = AW'(40); start = 1;
    @(posedge clk); #1; start = 0;
    c = 0;
    while (rd_req !== 1'b1 && c < 50) begin
      @(negedge clk); c++;
    end
    checks++;
    if (rd_req !== 1'b1) begin errors++; $display("FAIL reset_mid_no_req: rd_req=%b want 1", rd_req); end
    @(posedge clk); #1; reset = 1;
    #1;
    checks++;
    if ({busy, done, rd_req, fifo_reset, fifo_wr_en, fifo_rd_en, tx_start} !== 7'b0 ||
        rd_addr !== '0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_outputs: busy=%b rd_req=%b rd_addr=%h wr=%b rd=%b want all 0",
               busy, rd_req, rd_addr, fifo_wr_en, fifo_rd_en);
    end
    repeat (2) @(posedge clk);
    #1; reset = 0;
    @(negedge clk); #1; force_ack = 1;
    @(negedge clk);
    checks++;
    if (fifo_wr_en !== 1'b0 || rd_ack !== 1'b1) begin
      errors++; $display("FAIL stale_ack: fifo_wr_en=%b rd_ack=%b want 0 1", fifo_wr_en, rd_ack);
    end
    #1; force_ack = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL reset_mid_done: got %0d want 0", done_cnt); end
    run_readout(AW'(16'h700), AW'(5), 2, 1, 1'b0);
  endtask

  task automatic test_checksum_words();
    mem[16'h200] = 16'hA5F0;
    mem[16'h201] = 16'h0F0F;
    run_readout(AW'(16'h200), AW'(2), 3, 3, 1'b0);
`ifdef UART_CHECKSUM_EN
    checks++;
    if (rx.size() != 5 || rx[4] !== 8'h55) begin
      errors++; $display("FAIL checksum_byte: got %0d bytes, want 5 ending in 55", rx.size());
    end
`else
    checks++;
    if (rx.size() != 4 || rx[0] !== 8'hA5 || rx[3] !== 8'h0F) begin
      errors++; $display("FAIL cs_words: got %0d bytes, want A5 F0 0F 0F", rx.size());
    end
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 5; k++) begin
      run_readout(AW'($urandom_range(0, 3000)), AW'($urandom_range(1, 23)),
                  $urandom_range(1, 6), $urandom_range(0, 5), 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
    test_reset();
    test_basic();
    test_padding();
    test_zero_count();
    test_checksum_words();
    test_reset_mid();
    test_random();
    test_backpressure();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
